// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver delivering bytes over valid/ready,
// with one-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int   BW = 16,
    parameter logic RV = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DIN,
    input  logic [BW-1:0] BAUDDIV,
    output logic [7:0]    DOUT,
    output logic          DVALID,
    input  logic          DREADY,
    output logic          FERR,
    output logic          OVR,
    output logic          BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [BW-1:0] cnt;
    logic [BW-1:0] ndiv;
    logic [BW-1:0] half;
    logic [BW-1:0] ndiv_in;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          latch;
    logic          shift;
    logic          deliver;
    logic          frame_err;
    logic          cnt_clr;

    // Very short divisors leave no room for a mid-bit sample.
    assign ndiv_in = (BAUDDIV < BW'(3)) ? BW'(3) : BAUDDIV;
    assign half    = ndiv >> 1;
    assign BUSY    = (state != IDLE);

    always_comb begin
        state_n   = state;
        latch     = 1'b0;
        shift     = 1'b0;
        deliver   = 1'b0;
        frame_err = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (DIN == ~RV) begin
                    state_n = START;
                    latch   = 1'b1;
                end
            end
            START: begin
                if (cnt == half)
                    state_n = (DIN == ~RV) ? DATA : IDLE;
            end
            DATA: begin
                if (cnt == ndiv) begin
                    shift = 1'b1;
                    if (bidx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == ndiv) begin
                    if (DIN == RV) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_n   = BRK;
                    end
                end
            end
            BRK: begin
                if (DIN == RV)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        cnt_clr = shift || (state_n != state) || (state == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            ndiv   <= '0;
            bidx   <= '0;
            shreg  <= '0;
            DOUT   <= '0;
            DVALID <= 1'b0;
            FERR   <= 1'b0;
            OVR    <= 1'b0;
        end else begin
            cnt  <= cnt_clr ? '0 : cnt + BW'(1);
            FERR <= frame_err;
            OVR  <= 1'b0;
            if (latch)
                ndiv <= ndiv_in;
            if (state == START)
                bidx <= '0;
            if (shift) begin
                shreg <= {DIN, shreg[7:1]};
                bidx  <= bidx + 3'd1;
            end
            if (DVALID && DREADY)
                DVALID <= 1'b0;
            // A byte accepted in this same cycle frees the slot.
            if (deliver) begin
                if (!DVALID || DREADY) begin
                    DOUT   <= shreg;
                    DVALID <= 1'b1;
                end else begin
                    OVR <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames on a cycle-scheduled line, expected
// bytes scoreboarded and popped on each valid/ready transfer.
module tb_uart_rx;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b1;
    logic        DREADY  = 1'b1;
    logic [15:0] BAUDDIV = 16'd15;
    logic [7:0]  DOUT;
    logic        DVALID;
    logic        FERR;
    logic        OVR;
    logic        BUSY;

    logic        tx_line = 1'b1;
    int          cyc     = 0;
    logic        line_q[$];
    logic [7:0]  exp_q[$];
    int          total   = 0;
    int          passed  = 0;
    int          t0;
    int          t1;

    uart_rx #(.BW(16), .RV(1'b1)) dut (
        .CLK(CLK),
        .RST(RST),
        .DIN(tx_line),
        .BAUDDIV(BAUDDIV),
        .DOUT(DOUT),
        .DVALID(DVALID),
        .DREADY(DREADY),
        .FERR(FERR),
        .OVR(OVR),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Line player: one queued level per clock, idle mark when empty.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (line_q.size() != 0)
            tx_line <= line_q.pop_front();
        else
            tx_line <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge CLK) begin
        if (!RST && DVALID && DREADY) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("sb_byte", 32'(DOUT), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_level(input logic v, input int k);
        for (int i = 0; i < k; i++)
            line_q.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic stop,
                              input int n, output int ts);
        ts = cyc + 1 + line_q.size();
        push_level(1'b0, n + 1);
        for (int i = 0; i < 8; i++)
            push_level(d[i], n + 1);
        push_level(stop, n + 1);
    endtask

    task automatic gap();
        wait_until(cyc + line_q.size() + 6);
    endtask

    initial begin
        #1;
        wait_until(3);
        chk("rst_dout", 32'(DOUT), 32'h00);
        chk("rst_dvalid", 32'(DVALID), 32'd0);
        chk("rst_ferr", 32'(FERR), 32'd0);
        chk("rst_ovr", 32'(OVR), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        wait_until(6);

        // basic byte
        push_frame(8'hA5, 1'b1, 15, t0);
        exp_q.push_back(8'hA5);
        wait_until(t0);
        chk("basic_busy_t0", 32'(BUSY), 32'd0);
        wait_until(t0 + 1);
        chk("basic_busy_t1", 32'(BUSY), 32'd1);
        wait_until(t0 + 152);
        chk("basic_busy_152", 32'(BUSY), 32'd1);
        chk("basic_dv_152", 32'(DVALID), 32'd0);
        wait_until(t0 + 153);
        chk("basic_dv_153", 32'(DVALID), 32'd1);
        chk("basic_dout", 32'(DOUT), 32'hA5);
        chk("basic_ferr", 32'(FERR), 32'd0);
        chk("basic_ovr", 32'(OVR), 32'd0);
        chk("basic_busy_153", 32'(BUSY), 32'd0);
        wait_until(t0 + 154);
        chk("basic_dv_154", 32'(DVALID), 32'd0);
        gap();

        // glitch reject
        t0 = cyc + 1 + line_q.size();
        push_level(1'b0, 4);
        wait_until(t0 + 8);
        chk("glitch_busy_8", 32'(BUSY), 32'd1);
        wait_until(t0 + 9);
        chk("glitch_busy_9", 32'(BUSY), 32'd0);
        chk("glitch_dv", 32'(DVALID), 32'd0);
        chk("glitch_ferr", 32'(FERR), 32'd0);
        gap();
        push_frame(8'h3C, 1'b1, 15, t0);
        exp_q.push_back(8'h3C);
        wait_until(t0 + 153);
        chk("glitch_next_dv", 32'(DVALID), 32'd1);
        chk("glitch_next_dout", 32'(DOUT), 32'h3C);
        gap();

        // framing error, held break, then recovery
        push_frame(8'h55, 1'b0, 15, t0);
        push_level(1'b0, 40);
        wait_until(t0 + 153);
        chk("ferr_pulse", 32'(FERR), 32'd1);
        chk("ferr_dv", 32'(DVALID), 32'd0);
        chk("ferr_ovr", 32'(OVR), 32'd0);
        wait_until(t0 + 154);
        chk("ferr_clear", 32'(FERR), 32'd0);
        wait_until(t0 + 190);
        chk("ferr_brk_busy", 32'(BUSY), 32'd1);
        wait_until(t0 + 202);
        chk("ferr_brk_exit", 32'(BUSY), 32'd0);
        gap();
        push_frame(8'h5A, 1'b1, 15, t0);
        exp_q.push_back(8'h5A);
        wait_until(t0 + 153);
        chk("ferr_next_dout", 32'(DOUT), 32'h5A);
        gap();

        // overrun with back-to-back frames
        BAUDDIV = 16'd7;
        DREADY  = 1'b0;
        push_frame(8'h11, 1'b1, 7, t0);
        push_frame(8'h22, 1'b1, 7, t1);
        exp_q.push_back(8'h11);
        wait_until(t0 + 77);
        chk("ovr_first_dv", 32'(DVALID), 32'd1);
        chk("ovr_first_dout", 32'(DOUT), 32'h11);
        wait_until(t1 + 77);
        chk("ovr_pulse", 32'(OVR), 32'd1);
        chk("ovr_ferr", 32'(FERR), 32'd0);
        chk("ovr_dout_held", 32'(DOUT), 32'h11);
        wait_until(t1 + 78);
        chk("ovr_clear", 32'(OVR), 32'd0);
        wait_until(t1 + 80);
        DREADY = 1'b1;
        wait_until(t1 + 81);
        chk("ovr_consumed", 32'(DVALID), 32'd0);
        gap();

        // ready on the second stop-sample cycle frees the slot
        DREADY = 1'b0;
        push_frame(8'h11, 1'b1, 7, t0);
        push_frame(8'h22, 1'b1, 7, t1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        wait_until(t1 + 76);
        DREADY = 1'b1;
        wait_until(t1 + 77);
        DREADY = 1'b0;
        chk("b2b_dout", 32'(DOUT), 32'h22);
        chk("b2b_dv", 32'(DVALID), 32'd1);
        chk("b2b_ovr", 32'(OVR), 32'd0);
        wait_until(t1 + 80);
        DREADY = 1'b1;
        gap();

        // reset in the middle of data bit 3
        BAUDDIV = 16'd15;
        push_frame(8'hF8, 1'b1, 15, t0);
        wait_until(t0 + 70);
        RST = 1'b1;
        wait_until(t0 + 71);
        chk("mrst_dout", 32'(DOUT), 32'h00);
        chk("mrst_busy", 32'(BUSY), 32'd0);
        chk("mrst_dv", 32'(DVALID), 32'd0);
        RST = 1'b0;
        gap();
        push_frame(8'hC3, 1'b1, 15, t0);
        exp_q.push_back(8'hC3);
        wait_until(t0 + 153);
        chk("mrst_next_dout", 32'(DOUT), 32'hC3);
        gap();

        // divider clamp and mid-frame latch
        BAUDDIV = 16'd0;
        push_frame(8'hF0, 1'b1, 3, t0);
        exp_q.push_back(8'hF0);
        wait_until(t0 + 39);
        chk("clamp_dv", 32'(DVALID), 32'd1);
        chk("clamp_dout", 32'(DOUT), 32'hF0);
        gap();
        BAUDDIV = 16'd15;
        push_frame(8'h96, 1'b1, 15, t0);
        exp_q.push_back(8'h96);
        wait_until(t0 + 20);
        BAUDDIV = 16'd31;
        wait_until(t0 + 153);
        chk("latch_dv", 32'(DVALID), 32'd1);
        chk("latch_dout", 32'(DOUT), 32'h96);
        gap();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 format (start bit, 8 data bits LSB first, 1 stop bit).
- Sits directly downstream of the line debouncer in the serial path and consumes its debounced, synchronised RX level as DIN.
- Delivers each received byte through a valid/ready handshake to the command/packet logic.
- Flags framing errors and overruns.

Parameters:
BW, 16, width of the baud divider input and bit-timing counter
RV, 1'b1, idle (mark) level of DIN; start bit is ~RV, stop bit is RV

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
DIN  input  1  debounced serial line, already synchronous to CLK
BAUDDIV  input  BW  clocks per bit minus 1 (N); bit period = N+1 clocks
DOUT  output  8  received byte
DVALID  output  1  DOUT holds an unconsumed byte
DREADY  input  1  consumer accepts the byte when DVALID&&DREADY
FERR  output  1  one-cycle pulse: stop bit sampled as ~RV
OVR  output  1  one-cycle pulse: complete byte dropped because DVALID was still held
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous and active-high. All state is cleared on the first CLK edge with RST=1, including mid-frame.
  - State = IDLE.
  - DOUT = 8'h00, DVALID = 0, FERR = 0, OVR = 0, BUSY = 0.
  - Counter and shift register = 0.
- Divider: BAUDDIV is latched into ndiv in the cycle IDLE detects a start.
  - Latched values below 3 are replaced by 3.
  - Changes to BAUDDIV mid-frame have no effect.
- Half point: h = ndiv>>1.
- State machine (cnt is a BW-bit counter, zeroed on every state entry):
  - IDLE: if DIN==~RV, go to START; latch ndiv.
  - START: cnt increments every cycle. At cnt==h, sample DIN:
    - DIN==~RV: go to DATA, bit index = 0.
    - Otherwise: glitch; return to IDLE with no outputs.
  - DATA: at cnt==ndiv, shift the sampled DIN in LSB-first and restart cnt.
    - After the 8th bit, go to STOP.
  - STOP: at cnt==ndiv, sample DIN:
    - DIN==RV: deliver the byte (see Delivery below), then go to IDLE.
    - Otherwise: FERR=1 for one cycle, discard the byte, go to BRK.
  - BRK: wait for DIN==RV, then go to IDLE. Prevents a held-low line (break) from being re-read as start bits.
- Timing: let t0 be the cycle IDLE samples DIN==~RV.
  - Start sample at t0+1+h.
  - Data bit i sample at t0+1+h+(i+1)(ndiv+1).
  - Stop sample at t0+1+h+9(ndiv+1).
  - DVALID/FERR/OVR become visible at t0+2+h+9(ndiv+1).
  - Back-to-back frames: IDLE is re-entered mid stop bit, so the next start edge is caught with no lost cycles.
- Delivery on a good stop bit, evaluated in the stop-sample cycle:
  - DVALID==0, or DVALID&&DREADY in that same cycle: DOUT <= byte, DVALID <= 1.
  - DVALID==1 and DREADY==0: byte dropped, DOUT unchanged, OVR=1 for one cycle.
- Handshake:
  - DVALID stays high and DOUT stays stable until the cycle with DVALID&&DREADY.
  - DVALID clears the following cycle unless a new byte loads in that same cycle.
  - DREADY is ignored while DVALID=0.
- FERR and OVR never assert in the same cycle. A framing-error frame never sets DVALID.

Test Plan:
- Basic byte: N=15, RV=1, send 0xA5 8N1, DREADY=1 -> DOUT=8'hA5 and DVALID=1 at exactly t0+153 for one cycle; FERR=OVR=0; BUSY=1 from t0+1 to t0+152.
- Glitch reject: N=15, DIN low for 4 clocks then high -> state returns to IDLE at t0+8; DVALID, FERR and BUSY are low after t0+8; next valid frame 0x3C received correctly.
- Framing error: N=15, send 0x55 with stop bit = 0 and the line held low 40 more clocks -> FERR pulse at t0+153, DVALID stays 0; a 0x5A frame started before the line returns high is ignored; after the line goes high, 0x5A is received.
- Overrun/back-to-back: N=7, send 0x11 then 0x22 contiguously with DREADY=0 -> DOUT=8'h11 held, OVR pulse at the second delivery cycle; raise DREADY -> 0x11 consumed, DVALID=0 next cycle. Repeat with DREADY pulsed exactly on the second stop-sample cycle -> DOUT=8'h22, no OVR.
- Reset mid-frame: assert RST for 1 cycle during data bit 3 -> all outputs 0 and BUSY=0 next cycle; following frame 0xC3 received intact.
- Divider clamp and latch: BAUDDIV=0 -> receiver uses 4 clocks/bit, 0xF0 sent at 4 clocks/bit is received. Change BAUDDIV from 15 to 31 mid-frame -> current frame still decoded at 16 clocks/bit.
